// File: rtl/gray_to_bin_seq.sv
// Iterative Gray-to-binary decoder: resolves BITS_PER_CYCLE bits per cycle, MSB chunk first.
// Latency NCHUNK edges from accept to out_valid; holds result in DONE until out_ready, one word per NCHUNK+2 cycles.
module gray_to_bin_seq #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / BITS_PER_CYCLE;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (BITS_PER_CYCLE < 1 || WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
        $error("gray_to_bin_seq: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    gray_q, gray_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [WIDTH-1:0]    out_bin_q, out_bin_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    int                        lo;
    logic                      carry;
    logic [BITS_PER_CYCLE-1:0] g_chunk;
    logic [BITS_PER_CYCLE-1:0] res;
    logic [WIDTH-1:0]          mask;
    logic [WIDTH-1:0]          conv_word;

    // One chunk of the XOR chain: each result bit is the bit above the chunk
    // (0 above the MSB) XORed with all Gray bits from the chunk top down to it.
    always_comb begin
        lo      = WIDTH - BITS_PER_CYCLE * (int'(cnt_q) + 1);
        carry   = 1'(({1'b0, bin_q}) >> (lo + BITS_PER_CYCLE));
        g_chunk = BITS_PER_CYCLE'(gray_q >> lo);
        res     = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            res[j] = carry ^ (^(g_chunk >> j));
        end
        mask      = WIDTH'({BITS_PER_CYCLE{1'b1}}) << lo;
        conv_word = (bin_q & ~mask) | (WIDTH'(res) << lo);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CONV;
            CONV:    if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_bin   = out_bin_q;
    end

    always_comb begin
        gray_d    = gray_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        out_bin_d = out_bin_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    gray_d = in_gray;
                    bin_d  = '0;
                    cnt_d  = '0;
                end
            end
            CONV: begin
                bin_d = conv_word;
                if (cnt_q == LAST) begin
                    out_bin_d = conv_word;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q    <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            out_bin_q <= '0;
        end else begin
            gray_q    <= gray_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            out_bin_q <= out_bin_d;
        end
    end

endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Directed bench for gray_to_bin_seq: default, 4-bit-chunk and single-cycle instances.
module tb_gray_to_bin_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_iv, a_ir, a_ov, a_or, a_busy;
    logic [7:0] a_ig, a_ob;
    logic       b_iv, b_ir, b_ov, b_or, b_busy;
    logic [7:0] b_ig, b_ob;
    logic       c_iv, c_ir, c_ov, c_or, c_busy;
    logic [7:0] c_ig, c_ob;

    gray_to_bin_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_gray(a_ig),
        .out_valid(a_ov), .out_ready(a_or), .out_bin(a_ob), .busy(a_busy));
    gray_to_bin_seq #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_gray(b_ig),
        .out_valid(b_ov), .out_ready(b_or), .out_bin(b_ob), .busy(b_busy));
    gray_to_bin_seq #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_gray(c_ig),
        .out_valid(c_ov), .out_ready(c_or), .out_bin(c_ob), .busy(c_busy));

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] sbq[$];
    int         rise_cyc;
    int         prev_rise;
    int         lat;
    logic [7:0] bb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer g to instance A, check latency, optionally stall the output
    // for 'hold' cycles, then handshake and score the result.
    task automatic run_a(input logic [7:0] g, input logic [7:0] exp, input int hold);
        int t;
        int l;
        logic [7:0] e;
        a_ig = g;
        a_iv = 1'b1;
        t    = 0;
        while (a_ir !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        chk("in_ready_before_accept", a_ir, 1);
        tick();
        a_iv = 1'b0;
        sbq.push_back(exp);
        chk("in_ready_drop", a_ir, 0);
        l = 0;
        while (a_ov !== 1'b1 && l < 40) begin
            tick();
            l++;
        end
        chk("latency_a", l, 8);
        for (int i = 0; i < hold; i++) begin
            a_iv = 1'b1;
            a_ig = 8'h3C;
            tick();
            chk("bp_out_bin", a_ob, sbq[0]);
            chk("bp_out_valid", a_ov, 1);
            chk("bp_in_ready", a_ir, 0);
        end
        e = sbq.pop_front();
        chk("out_bin_a", a_ob, e);
        a_or = 1'b1;
        tick();
        a_or = 1'b0;
        a_iv = 1'b0;
        chk("out_valid_clear", a_ov, 0);
        chk("in_ready_back", a_ir, 1);
        chk("busy_clear", a_busy, 0);
        chk("out_bin_kept", a_ob, e);
        rise_cyc = cyc;
    endtask

    initial begin
        rst  = 1'b1;
        a_iv = 1'b1; a_ig = 8'hB4; a_or = 1'b0;
        b_iv = 1'b0; b_ig = 8'h00; b_or = 1'b1;
        c_iv = 1'b0; c_ig = 8'h00; c_or = 1'b1;
        #1;
        chk("rst_in_ready", a_ir, 1);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_out_bin", a_ob, 8'h00);
        chk("rst_busy", a_busy, 0);
        tick();
        tick();
        chk("rst_held_in_ready", a_ir, 1);
        chk("rst_held_out_valid", a_ov, 0);
        rst = 1'b0;

        run_a(8'hB4, 8'hD8, 0);

        run_a(8'hB4, 8'hD8, 5);

        run_a(8'h00, 8'h00, 0);
        prev_rise = rise_cyc;
        run_a(8'h80, 8'hFF, 0);
        chk("ready_spacing_1", rise_cyc - prev_rise, 10);
        prev_rise = rise_cyc;
        run_a(8'hFF, 8'hAA, 0);
        chk("ready_spacing_2", rise_cyc - prev_rise, 10);
        prev_rise = rise_cyc;
        run_a(8'h01, 8'h01, 0);
        chk("ready_spacing_3", rise_cyc - prev_rise, 10);

        // Abort a conversion of 8'hFF at cnt=3 with an asynchronous reset.
        a_ig = 8'hFF;
        a_iv = 1'b1;
        tick();
        a_iv = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_abort_busy", a_busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", a_ov, 0);
        chk("abort_out_bin", a_ob, 8'h00);
        chk("abort_in_ready", a_ir, 1);
        chk("abort_busy", a_busy, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_no_result", a_ov, 0);
        end

        // BITS_PER_CYCLE=4: two edges.
        b_ig = 8'hB4;
        b_iv = 1'b1;
        chk("b_in_ready", b_ir, 1);
        tick();
        b_iv = 1'b0;
        sbq.push_back(8'hD8);
        lat = 0;
        while (b_ov !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency_b", lat, 2);
        chk("out_bin_b", b_ob, sbq.pop_front());

        // BITS_PER_CYCLE=8: one edge.
        c_ig = 8'hB4;
        c_iv = 1'b1;
        chk("c_in_ready", c_ir, 1);
        tick();
        c_iv = 1'b0;
        sbq.push_back(8'hD8);
        lat = 0;
        while (c_ov !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency_c", lat, 1);
        chk("out_bin_c", c_ob, sbq.pop_front());

        for (int b = 0; b < 256; b++) begin
            bb = 8'(b);
            run_a(bb ^ (bb >> 1), bb, 0);
        end

        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_to_bin_seq.md
Name: gray_to_bin_seq

Overview:
- Sequential Gray-to-binary decoder; the inverse of the team's binary-to-Gray code converter.
  - binary MSB = Gray MSB
  - each lower binary bit = next-higher binary bit XOR the Gray bit at that position
- Iterative, so the MSB-to-LSB XOR chain is spread over multiple cycles.
- Sits between a Gray-coded source (encoder output, Gray counter) and binary consumers, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, word width in bits; WIDTH >= 2.
- BITS_PER_CYCLE, 1, binary bits resolved per CONV cycle.
  - WIDTH % BITS_PER_CYCLE must be 0.
  - Elaboration error otherwise.
- NCHUNK (localparam), WIDTH/BITS_PER_CYCLE, number of CONV cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_gray is valid
- in_ready  output  1  block can accept a word
- in_gray  input  WIDTH  Gray-coded input word
- out_valid  output  1  out_bin holds a finished result
- out_ready  input  1  downstream accepts out_bin
- out_bin  output  WIDTH  decoded binary word
- busy  output  1  high in CONV or DONE

Behaviour:
- Reset (async assert, released synchronously by design):
  - state=IDLE; in_ready=1; out_valid=0; out_bin=0; busy=0
  - internal Gray register and chunk counter = 0
- Reset mid-operation aborts the conversion. No partial result is ever presented.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, capture in_gray into the Gray register, clear cnt, go to CONV.
  - in_valid while not in IDLE is ignored. The source must hold the word until handshake.
- CONV:
  - in_ready=0; busy=1.
  - Each cycle resolves bits [WIDTH-1-cnt*BPC : WIDTH-BPC-cnt*BPC] of the working binary register, MSB chunk first.
  - Bit k = bin[k+1] ^ gray[k], chained combinationally inside the chunk.
  - Bit WIDTH-1 = gray[WIDTH-1].
  - cnt increments each cycle.
  - On the cycle with cnt==NCHUNK-1, load the completed word into out_bin, set out_valid=1, go to DONE.
- Latency:
  - out_valid rises exactly NCHUNK clock edges after the accepting edge.
  - Default parameters: 8 edges. BITS_PER_CYCLE=WIDTH: 1 edge.
- DONE:
  - out_valid=1; out_bin held stable while out_ready=0 (no changes, no glitches).
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - in_ready returns 1 on the following cycle. There is no same-cycle accept in DONE.
  - Throughput: one word per NCHUNK+2 cycles.
- out_bin keeps its last value after the handshake until the next result loads. Consumers must qualify it with out_valid.
- out_ready high while out_valid=0 has no effect.
- in_valid and out_ready changing in the same cycle need no special handling; the states are mutually exclusive.
- Arithmetic: pure XOR, no widths beyond WIDTH, no carries.
- Width: the MSB passes through unchanged for all WIDTH.

Test Plan:
- Reset with in_valid=1 held, release, send in_gray=8'hB4 -> in_ready drops next cycle; out_valid rises 8 edges after accept; out_bin=8'hD8.
- Back-to-back words 8'h00, 8'h80, 8'hFF, 8'h01 with out_ready tied 1 -> out_bin = 8'h00, 8'hFF, 8'hAA, 8'h01 in order; each in_ready rise is 10 cycles apart.
- Backpressure: send 8'hB4, hold out_ready=0 for 5 cycles after out_valid -> out_bin stays 8'hD8 and out_valid stays 1 throughout; a new in_valid is not accepted until after the out_ready handshake.
- Assert rst at CONV cnt=3 while decoding 8'hFF -> out_valid=0, out_bin=0, in_ready=1 immediately (async); no result appears afterwards.
- BITS_PER_CYCLE=4, WIDTH=8: in_gray=8'hB4 -> out_valid 2 edges after accept, out_bin=8'hD8. BITS_PER_CYCLE=8 gives 1 edge.
- Exhaustive WIDTH=8: all 256 Gray codes of the binary values 0..255 -> out_bin equals the original binary value for each code; compare with a scoreboard.
